// File: rtl/sram_to_sram_like_bridge.sv
// Bridge from a pipeline SRAM-style port to the SRAM-like bus (cache / AXI-bridge side).
// Handles read and optional write accesses, and a flush that abandons or drains an access.
module sram_to_sram_like_bridge #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned WRITE_EN = 1
) (
  input  logic              clk,
  input  logic              resetn,
  // Pipeline side
  input  logic              sram_en,
  input  logic [3:0]        sram_wen,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_wdata,
  output logic [31:0]       sram_rdata,
  output logic              stall,
  input  logic              all_stall,
  input  logic              flush,
  // SRAM-like side
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [31:0]       rdata
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StData  = 2'd1,
    StDone  = 2'd2,
    StDrain = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_q, wr_d;

  logic        is_wr;
  logic [1:0]  wr_addr_lo;
  logic [1:0]  wr_size;

  assign is_wr = (WRITE_EN != 0) && (sram_wen != 4'b0000);

  // Byte-enable pattern to sub-word address offset and transfer size.
  always_comb begin
    wr_addr_lo = 2'b00;
    wr_size    = 2'd2;
    case (sram_wen)
      4'b0001: begin wr_addr_lo = 2'b00; wr_size = 2'd0; end
      4'b0010: begin wr_addr_lo = 2'b01; wr_size = 2'd0; end
      4'b0100: begin wr_addr_lo = 2'b10; wr_size = 2'd0; end
      4'b1000: begin wr_addr_lo = 2'b11; wr_size = 2'd0; end
      4'b0011: begin wr_addr_lo = 2'b00; wr_size = 2'd1; end
      4'b1100: begin wr_addr_lo = 2'b10; wr_size = 2'd1; end
      default: begin wr_addr_lo = 2'b00; wr_size = 2'd2; end
    endcase
  end

  assign wr    = is_wr;
  assign size  = is_wr ? wr_size : 2'd2;
  assign addr  = is_wr ? {sram_addr[ADDR_W-1:2], wr_addr_lo} : sram_addr;
  assign wdata = sram_wdata;

  // Gated by reset so nothing reaches the bus or pipeline while held in reset.
  assign req   = resetn & (state_q == StIdle) & sram_en & ~flush;
  assign stall = resetn & ((sram_en & ~flush & (state_q != StDone)) | (state_q == StDrain));

  assign sram_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    unique case (state_q)
      StIdle: begin
        if (req && addr_ok) begin
          wr_d = is_wr;
          if (data_ok) begin
            state_d = StDone;
            if (!is_wr) rdata_d = rdata;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (data_ok && flush) begin
          state_d = StIdle;
        end else if (data_ok) begin
          state_d = StDone;
          if (!wr_q) rdata_d = rdata;
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StDone: begin
        // data_ok here is a protocol error and is deliberately ignored.
        if (flush || !all_stall) state_d = StIdle;
      end
      StDrain: begin
        if (data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      rdata_q <= 32'h0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_sram_to_sram_like_bridge.sv
// Directed bench for sram_to_sram_like_bridge: a read/write instance and a read-only instance
// share stimulus; outputs are checked after inputs settle, between clock edges.
module tb_sram_to_sram_like_bridge;

  logic        clk;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        all_stall;
  logic        flush;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  logic [31:0] sram_rdata_w, sram_rdata_r;
  logic        stall_w, stall_r;
  logic        req_w, req_r;
  logic        wr_w, wr_r;
  logic [1:0]  size_w, size_r;
  logic [31:0] addr_w, addr_r;
  logic [31:0] wdata_w, wdata_r;

  int n_vec;
  int n_err;

  sram_to_sram_like_bridge #(.ADDR_W(32), .WRITE_EN(1)) dut_w (
    .clk(clk), .resetn(resetn),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata_w), .stall(stall_w), .all_stall(all_stall), .flush(flush),
    .req(req_w), .wr(wr_w), .size(size_w), .addr(addr_w), .wdata(wdata_w),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  sram_to_sram_like_bridge #(.ADDR_W(32), .WRITE_EN(0)) dut_r (
    .clk(clk), .resetn(resetn),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata_r), .stall(stall_r), .all_stall(all_stall), .flush(flush),
    .req(req_r), .wr(wr_r), .size(size_r), .addr(addr_r), .wdata(wdata_r),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st_w();
    return 32'(dut_w.state_q);
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    resetn = 1'b0; sram_en = 1'b1; sram_wen = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
    all_stall = 1'b0; flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
    #3;
    chk("rst_req", 32'(req_w), 32'd0);
    chk("rst_stall", 32'(stall_w), 32'd0);
    chk("rst_rdata", sram_rdata_w, 32'h0);
    chk("rst_state", st_w(), 32'd0);
    #9 resetn = 1'b1;

    // Read: addr_ok cycle 0, data_ok cycle 2.
    tick();
    sram_en = 1'b1; sram_addr = 32'h1fc0_0000; addr_ok = 1'b1; #1;
    chk("rd_c0_req", 32'(req_w), 32'd1);
    chk("rd_c0_stall", 32'(stall_w), 32'd1);
    chk("rd_c0_wr", 32'(wr_w), 32'd0);
    chk("rd_c0_size", 32'(size_w), 32'd2);
    chk("rd_c0_addr", addr_w, 32'h1fc0_0000);
    tick();
    addr_ok = 1'b0; #1;
    chk("rd_c1_state", st_w(), 32'd1);
    chk("rd_c1_req", 32'(req_w), 32'd0);
    chk("rd_c1_stall", 32'(stall_w), 32'd1);
    tick();
    data_ok = 1'b1; rdata = 32'h3c1d_0001; #1;
    chk("rd_c2_req", 32'(req_w), 32'd0);
    chk("rd_c2_stall", 32'(stall_w), 32'd1);
    tick();
    data_ok = 1'b0; rdata = 32'h0; #1;
    chk("rd_c3_state", st_w(), 32'd2);
    chk("rd_c3_stall", 32'(stall_w), 32'd0);
    chk("rd_c3_req", 32'(req_w), 32'd0);
    chk("rd_c3_rdata", sram_rdata_w, 32'h3c1d_0001);
    tick();
    sram_en = 1'b0; #1;
    chk("rd_c4_state", st_w(), 32'd0);

    // Read with addr_ok and data_ok together.
    tick();
    sram_en = 1'b1; sram_addr = 32'h0000_0100; addr_ok = 1'b1; data_ok = 1'b1;
    rdata = 32'h1234_5678; #1;
    chk("fast_req", 32'(req_w), 32'd1);
    tick();
    sram_en = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0; #1;
    chk("fast_state", st_w(), 32'd2);
    chk("fast_rdata", sram_rdata_w, 32'h1234_5678);
    chk("fast_stall", 32'(stall_w), 32'd0);
    tick();
    chk("fast_idle", st_w(), 32'd0);

    // Write mapping, combinational on both instances.
    sram_en = 1'b1; sram_wen = 4'b0100; sram_addr = 32'h8000_0004; sram_wdata = 32'h00ab_0000;
    #1;
    chk("w0100_req", 32'(req_w), 32'd1);
    chk("w0100_wr", 32'(wr_w), 32'd1);
    chk("w0100_size", 32'(size_w), 32'd0);
    chk("w0100_addr", addr_w, 32'h8000_0006);
    chk("w0100_wdata", wdata_w, 32'h00ab_0000);
    chk("ro_wr", 32'(wr_r), 32'd0);
    chk("ro_size", 32'(size_r), 32'd2);
    chk("ro_addr", addr_r, 32'h8000_0004);
    sram_wen = 4'b1100; #1;
    chk("w1100_size", 32'(size_w), 32'd1);
    chk("w1100_addr", addr_w, 32'h8000_0006);
    sram_wen = 4'b1000; #1;
    chk("w1000_size", 32'(size_w), 32'd0);
    chk("w1000_addr", addr_w, 32'h8000_0007);
    sram_wen = 4'b0010; #1;
    chk("w0010_addr", addr_w, 32'h8000_0005);
    sram_wen = 4'b0011; #1;
    chk("w0011_size", 32'(size_w), 32'd1);
    chk("w0011_addr", addr_w, 32'h8000_0004);
    sram_wen = 4'b1111; #1;
    chk("w1111_size", 32'(size_w), 32'd2);
    sram_wen = 4'b0101; #1;
    chk("w0101_size", 32'(size_w), 32'd2);
    chk("w0101_addr", addr_w, 32'h8000_0004);

    // Complete the write; the read-only instance treats it as a read.
    addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'haaaa_5555;
    tick();
    sram_en = 1'b0; sram_wen = 4'h0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0; #1;
    chk("wr_done_state", st_w(), 32'd2);
    chk("wr_keeps_rdata", sram_rdata_w, 32'h1234_5678);
    chk("ro_captures", sram_rdata_r, 32'haaaa_5555);
    tick();

    // Flush while in DATA, then drain.
    sram_en = 1'b1; sram_addr = 32'h0000_0200; addr_ok = 1'b1; #1;
    tick();
    addr_ok = 1'b0; flush = 1'b1; #1;
    chk("fl_in_data", st_w(), 32'd1);
    tick();
    flush = 1'b0; sram_en = 1'b1; sram_addr = 32'h0000_0300; addr_ok = 1'b1; #1;
    chk("fl_drain_state", st_w(), 32'd3);
    chk("fl_drain_stall", 32'(stall_w), 32'd1);
    chk("fl_drain_req", 32'(req_w), 32'd0);
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hdead_beef; #1;
    chk("fl_drain_hold", st_w(), 32'd3);
    chk("fl_drain_req2", 32'(req_w), 32'd0);
    tick();
    data_ok = 1'b0; rdata = 32'h0; #1;
    chk("fl_idle", st_w(), 32'd0);
    chk("fl_rdata_kept", sram_rdata_w, 32'h1234_5678);
    chk("fl_next_req", 32'(req_w), 32'd1);
    flush = 1'b1; #1;
    chk("fl_idle_req", 32'(req_w), 32'd0);
    chk("fl_idle_stall", 32'(stall_w), 32'd0);
    tick();
    flush = 1'b0; sram_en = 1'b0; #1;
    chk("fl_idle_stay", st_w(), 32'd0);

    // Completion held by all_stall; data_ok in DONE ignored.
    tick();
    sram_en = 1'b1; sram_addr = 32'h0000_0400; addr_ok = 1'b1; #1;
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hcafe_f00d; all_stall = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      data_ok = (i == 1); rdata = (i == 1) ? 32'h1111_1111 : 32'h0; #1;
      chk("as_state", st_w(), 32'd2);
      chk("as_stall", 32'(stall_w), 32'd0);
      chk("as_req", 32'(req_w), 32'd0);
      chk("as_rdata", sram_rdata_w, 32'hcafe_f00d);
    end
    tick();
    data_ok = 1'b0; rdata = 32'h0; all_stall = 1'b0; #1;
    chk("as_rdata_err", sram_rdata_w, 32'hcafe_f00d);
    chk("as_release_state", st_w(), 32'd2);
    tick();
    sram_en = 1'b0; #1;
    chk("as_idle", st_w(), 32'd0);

    // Reset pulse while in DATA.
    tick();
    sram_en = 1'b1; sram_addr = 32'h0000_0500; addr_ok = 1'b1; #1;
    tick();
    addr_ok = 1'b0; #1;
    chk("rs_in_data", st_w(), 32'd1);
    resetn = 1'b0; #1;
    chk("rs_state", st_w(), 32'd0);
    chk("rs_rdata", sram_rdata_w, 32'h0);
    chk("rs_stall", 32'(stall_w), 32'd0);
    chk("rs_req", 32'(req_w), 32'd0);
    tick();
    resetn = 1'b1; sram_en = 1'b0; data_ok = 1'b1; rdata = 32'h5a5a_5a5a; #1;
    chk("rs_stale_req", 32'(req_w), 32'd0);
    tick();
    data_ok = 1'b0; rdata = 32'h0; #1;
    chk("rs_stale_state", st_w(), 32'd0);
    chk("rs_stale_rdata", sram_rdata_w, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
